// File: rtl/ppg_pkg.sv
// Shared types and default geometry for the pulse train generator.
package ppg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int unsigned DEF_SER_W   = 8;
  localparam int unsigned DEF_COORD_W = 10;
  localparam int unsigned OFS_W       = $clog2(DEF_SER_W);
  localparam int unsigned IDX_W       = DEF_COORD_W - OFS_W;

endpackage

// File: rtl/ppg_event_fifo.sv
// Show-ahead synchronous FIFO holding queued event coordinates.
module ppg_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pulse_train_generator.sv
// Plays queued event coordinates out as a framed pulse train of SER_W-bit words, LSB first.
module pulse_train_generator
  import ppg_pkg::*;
#(
  parameter int unsigned SER_W      = DEF_SER_W,
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_W    = 8,
  parameter int unsigned PW_W       = $clog2(SER_W + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          ev_valid_i,
  output logic                          ev_ready_o,
  input  logic [COORD_W-1:0]            ev_coord_i,
  input  logic [FRAME_W-1:0]            frame_words_i,
  input  logic [PW_W-1:0]               pulse_width_i,
  input  logic                          clear_i,
  output logic [SER_W-1:0]              pulse_o,
  output logic                          busy_o,
  output logic [15:0]                   late_cnt_o,
  output logic                          start_miss_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned OFS_B = $clog2(SER_W);
  localparam int unsigned IDX_B = COORD_W - OFS_B;
  localparam int unsigned CMP_W = (IDX_B > FRAME_W) ? IDX_B : FRAME_W;

  state_t             state;
  logic [FRAME_W-1:0] wc;
  logic [FRAME_W-1:0] last_wc;
  logic [PW_W-1:0]    pw;
  logic [SER_W-1:0]   carry;
  logic [SER_W-1:0]   word_q;

  logic [COORD_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CMP_W-1:0]   head_idx;
  logic [CMP_W-1:0]   wc_ext;
  logic               hit;
  logic               late;
  logic [2*SER_W-1:0] ones;
  logic [2*SER_W-1:0] pat;
  logic [SER_W-1:0]   next_word;
  logic [SER_W-1:0]   next_carry;

  assign ev_ready_o = !fifo_full;

  ppg_event_fifo #(
    .WIDTH(COORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (ev_valid_i && !fifo_full),
    .pop  (fifo_pop),
    .flush(clear_i && (state == IDLE)),
    .din  (ev_coord_i),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level_o)
  );

  // A word without a hit still emits the spill-over carried from the previous word.
  always_comb begin
    head_idx   = CMP_W'(head[COORD_W-1:OFS_B]);
    wc_ext     = CMP_W'(wc);
    hit        = (state == RUN) && !fifo_empty && (head_idx == wc_ext);
    late       = (state == RUN) && !fifo_empty && (head_idx < wc_ext);
    fifo_pop   = hit || late;
    ones       = ((2*SER_W)'(1) << pw) - (2*SER_W)'(1);
    pat        = ones << head[OFS_B-1:0];
    next_word  = carry;
    next_carry = '0;
    if (hit) begin
      next_word  = pat[SER_W-1:0] | carry;
      next_carry = pat[2*SER_W-1:SER_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wc           <= '0;
      last_wc      <= '0;
      pw           <= '0;
      carry        <= '0;
      word_q       <= '0;
      pulse_o      <= '0;
      busy_o       <= 1'b0;
      late_cnt_o   <= '0;
      start_miss_o <= 1'b0;
    end else begin
      word_q  <= next_word;
      pulse_o <= word_q;
      if (late && (late_cnt_o != 16'hFFFF)) late_cnt_o <= late_cnt_o + 1'b1;
      case (state)
        IDLE: begin
          carry <= '0;
          if (clear_i) start_miss_o <= 1'b0;
          if (start_i) begin
            state   <= RUN;
            busy_o  <= 1'b1;
            wc      <= '0;
            last_wc <= (frame_words_i == '0) ? '0 : frame_words_i - 1'b1;
            pw      <= (pulse_width_i > PW_W'(SER_W)) ? PW_W'(SER_W) : pulse_width_i;
          end
        end
        RUN: begin
          carry <= next_carry;
          wc    <= wc + 1'b1;
          if (start_i) start_miss_o <= 1'b1;
          if (wc == last_wc) state <= FLUSH;
        end
        FLUSH: begin
          carry  <= '0;
          state  <= IDLE;
          busy_o <= 1'b0;
          if (start_i) start_miss_o <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
